// File: rtl/gpio_serial_loader.sv
// gpio_serial_loader
// Snapshots one config word per GPIO pad and shifts the whole chain out
// serially (highest pad first, MSB first). It then raises a single latch
// strobe so that every pad takes its new configuration at the same time.
// All outputs come straight from flops, so the pad ring never sees glitches.
module gpio_serial_loader #(
   parameter int NUM_GPIO = 19,
   parameter int CFG_W    = 10,
   parameter int CLK_DIV  = 4
) (
   input  logic                      wb_clk_i,
   input  logic                      wb_rstn_i,
   input  logic                      start,
   input  logic [NUM_GPIO*CFG_W-1:0] cfg_data,
   output logic                      busy,
   output logic                      done,
   output logic                      serial_clock,
   output logic                      serial_data_out,
   output logic                      serial_load
);

   localparam int N     = NUM_GPIO * CFG_W;
   localparam int DIV_W = $clog2(CLK_DIV) + 1;
   localparam int BIT_W = $clog2(N) + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_LOAD  = 2'd2,
      ST_FIN   = 2'd3
   } state_t;

   state_t             r_state;
   logic [N-1:0]       r_snap;
   logic [DIV_W-1:0]   r_div;
   logic [BIT_W-1:0]   r_bit;
   logic               r_busy;
   logic               r_done;
   logic               r_sclk;
   logic               r_load;

   state_t             w_state_nxt;
   logic [N-1:0]       w_snap_nxt;
   logic [DIV_W-1:0]   w_div_nxt;
   logic [BIT_W-1:0]   w_bit_nxt;
   logic               w_busy_nxt;
   logic               w_done_nxt;
   logic               w_sclk_nxt;
   logic               w_load_nxt;
   logic               w_div_end;

   // The snapshot shifts left once per bit, so its top bit is always the bit on the wire.
   // In LOAD it is left alone, which keeps the last bit on the line.
   assign serial_data_out = r_snap[N-1];
   assign busy            = r_busy;
   assign done            = r_done;
   assign serial_clock    = r_sclk;
   assign serial_load     = r_load;

   assign w_div_end = (r_div == DIV_W'(CLK_DIV - 1));

   // Next-state and next-output decode for the loader sequence.
   always_comb begin
      w_state_nxt = r_state;
      w_snap_nxt  = r_snap;
      w_div_nxt   = r_div;
      w_bit_nxt   = r_bit;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      w_sclk_nxt  = r_sclk;
      w_load_nxt  = r_load;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = ST_SHIFT;
               w_snap_nxt  = cfg_data;
               w_div_nxt   = '0;
               w_bit_nxt   = '0;
               w_busy_nxt  = 1'b1;
               w_sclk_nxt  = 1'b0;
            end else begin
               w_busy_nxt  = 1'b0;
               w_sclk_nxt  = 1'b0;
               w_load_nxt  = 1'b0;
            end
         end
         ST_SHIFT: begin
            if (!w_div_end) begin
               w_div_nxt = r_div + DIV_W'(1);
            end else if (!r_sclk) begin
               // The low half-phase is over, so raise the chain clock.
               w_div_nxt  = '0;
               w_sclk_nxt = 1'b1;
            end else if (r_bit == BIT_W'(N - 1)) begin
               // The last bit is done, so go to LOAD and start the latch strobe.
               w_div_nxt   = '0;
               w_sclk_nxt  = 1'b0;
               w_load_nxt  = 1'b1;
               w_state_nxt = ST_LOAD;
            end else begin
               // Move to the next bit. The data changes here, at the start of the low phase.
               w_div_nxt  = '0;
               w_sclk_nxt = 1'b0;
               w_bit_nxt  = r_bit + BIT_W'(1);
               w_snap_nxt = r_snap << 1'b1;
            end
         end
         ST_LOAD: begin
            if (w_div_end) begin
               w_div_nxt   = '0;
               w_load_nxt  = 1'b0;
               w_done_nxt  = 1'b1;
               w_state_nxt = ST_FIN;
            end else begin
               w_div_nxt   = r_div + DIV_W'(1);
            end
         end
         ST_FIN: begin
            // A start in this cycle is deliberately ignored.
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
            w_snap_nxt  = '0;
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_snap_nxt  = '0;
            w_div_nxt   = '0;
            w_bit_nxt   = '0;
            w_busy_nxt  = 1'b0;
            w_sclk_nxt  = 1'b0;
            w_load_nxt  = 1'b0;
         end
      endcase
   end

   // State, counter, snapshot and output registers. The async reset forces every output low.
   always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
      if (!wb_rstn_i) begin
         r_state <= ST_IDLE;
         r_snap  <= '0;
         r_div   <= '0;
         r_bit   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_sclk  <= 1'b0;
         r_load  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_snap  <= w_snap_nxt;
         r_div   <= w_div_nxt;
         r_bit   <= w_bit_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_sclk  <= w_sclk_nxt;
         r_load  <= w_load_nxt;
      end
   end

endmodule
